trng_key_reader: RTL

//  Consumer end of the TRNG key handshake (key_ready / ack_key_read / key_out).

---
 rtl/trng_key_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/trng_key_reader.sv
// Consumer side of the TRNG key handshake: captures, acknowledges and buffers key words in a FIFO.
// Optional repetition-count health test is built in when TRNG_RCT_EN is defined.
module trng_key_reader #(
  parameter int NBITS_KEY  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  input  logic                        i_key_ready,
  input  logic [NBITS_KEY-1:0]        i_key_in,
  output logic                        o_ack_key_read,
  output logic                        o_rd_valid,
  input  logic                        i_rd_ready,
  output logic [NBITS_KEY-1:0]        o_rd_data,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  input  logic                        i_clr_err,
  output logic                        o_rct_fail
);

  // state     | meaning
  // S_IDLE    | waiting for a key while enabled and FIFO not full
  // S_ACK     | key captured, ack_key_read high this cycle
  // S_WAIT_DROP | waiting for producer to drop key_ready
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_DROP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_cap;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_count;
  logic [NBITS_KEY-1:0] r_mem [FIFO_DEPTH];

  assign w_full = (r_count == LW'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) & i_rd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable & i_key_ready & !w_full) begin
          w_cap       = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:       w_state_nxt = S_WAIT_DROP;
      S_WAIT_DROP: if (!i_key_ready) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign o_ack_key_read = (r_state == S_ACK);

`ifdef TRNG_RCT_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic [NBITS_KEY-1:0] r_prev;
  logic                 r_prev_v;
  logic [RW-1:0]        r_run;
  logic                 r_rct_fail;
  logic [RW-1:0]        w_run_nxt;
  logic                 w_trip;

  assign w_run_nxt = (r_prev_v && (i_key_in == r_prev)) ? r_run + RW'(1) : RW'(1);
  assign w_trip    = (w_run_nxt == RW'(RCT_CUTOFF));
  // clr_err overrides both an existing failure and a failure tripping this cycle
  assign w_push    = w_cap & (i_clr_err | !(r_rct_fail | w_trip));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_err) begin
      r_prev     <= '0;
      r_prev_v   <= 1'b0;
      r_run      <= '0;
      r_rct_fail <= 1'b0;
    end else if (w_cap && !r_rct_fail) begin
      r_prev   <= i_key_in;
      r_prev_v <= 1'b1;
      r_run    <= w_run_nxt;
      if (w_trip) r_rct_fail <= 1'b1;
    end
  end

  assign o_rct_fail = r_rct_fail;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_clr_err;
  assign w_push       = w_cap;
  assign o_rct_fail   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_key_in;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_valid   = (r_count != '0);
  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_fifo_level = r_count;

endmodule
